instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage directly upstream of instruction decode in the 5-stage MIPS pipeline.
- Owns the PC, issues one instruction-memory request at a time, and absorbs variable memory latency.
- Drives the IF/ID outputs `instructionReg`/`PCReg` consumed by decode.
- Obeys decode's `hazardDetected` stall and `PCSrcD`/`PCbranchD` branch redirect, and flushes wrong-path instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble instruction (sll $0,$0,0) inserted on flush or empty fetch.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- hazardDetected  in  1  decode stall; IF/ID outputs and PC must hold
- PCSrcD  in  1  taken-branch redirect from decode
- PCbranchD  in  32  branch target from decode
- imem_req  out  1  request valid to instruction memory
- imem_addr  out  32  request word address (= pc)
- imem_ready  in  1  memory accepts request this cycle (req & ready = handshake)
- imem_valid  in  1  response valid; at least 1 cycle after acceptance
- imem_rdata  in  32  response instruction
- instructionReg  out  32  IF/ID instruction
- PCReg  out  32  IF/ID PC+4 of that instruction
- validF  out  1  IF/ID holds a real (non-bubble) instruction

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, state=REQ, discard=0, skid empty.
  - instructionReg=NOP_INSTR, PCReg=0, validF=0.
  - imem_req=0 while reset is high.
- Redirect condition: redirect = PCSrcD & !hazardDetected. PCSrcD is ignored while stalled.
- At most one outstanding memory request.
- FSM states: REQ, WAIT, HOLD.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_ready → WAIT.
  - Before acceptance, imem_addr may change on redirect.
- WAIT:
  - imem_req=0.
  - On imem_valid with discard=1: drop the response, clear discard, → REQ.
  - On imem_valid with discard=0 and !hazardDetected: instructionReg=imem_rdata, PCReg=pc+4, validF=1, pc=pc+4, → REQ.
  - On imem_valid with discard=0 and hazardDetected: capture into skid buffer (instr, pc+4), pc=pc+4, → HOLD.
- HOLD:
  - imem_req=0.
  - When !hazardDetected: skid → IF/ID with validF=1, skid empty, → REQ.
- IF/ID update rules:
  - hazardDetected=1: instructionReg, PCReg and validF hold their values.
  - Not stalled and no instruction delivered this cycle: load NOP_INSTR, validF=0 (bubble).
- Redirect (highest priority when qualified):
  - pc=PCbranchD.
  - IF/ID loaded with NOP_INSTR, validF=0.
  - Skid invalidated.
  - In REQ with imem_ready the same cycle: the old address was accepted, so → WAIT with discard=1.
  - In REQ without ready: stay in REQ; next cycle addr=PCbranchD.
  - In WAIT without imem_valid: discard=1.
  - In WAIT with imem_valid the same cycle: response dropped, → REQ.
  - In HOLD: → REQ.
- Arithmetic: all PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0 with no flag. The low two address bits are passed through unchecked.
- Latency: with zero-wait memory (ready in REQ, valid the next cycle), one instruction reaches IF/ID every 2 cycles. First valid instruction appears 2 cycles after reset deassert.
- Reset asserted mid-request: any later imem_valid is ignored because state=REQ. The memory must tolerate the abandoned request.

Decomposition:
- Shared package `pipeline_pkg`:
  - fetch state enum {REQ, WAIT, HOLD}
  - NOP_INSTR constant
  - word width constant (32)
- One natural sub-module: `fetch_skid_buffer`, a 1-entry instr+PC holding register with load/unload/clear.

Test Plan:
- Reset then zero-wait memory returning 0x2001_0005 at 0x0 → IF/ID=0x2001_0005, PCReg=0x4, validF=1, and next imem_addr=0x4.
- hazardDetected held for 3 cycles while response 0x8C22_0000 arrives in WAIT → skid captures it, IF/ID unchanged; on release IF/ID=0x8C22_0000, PCReg=pc+4.
- PCSrcD=1, PCbranchD=0x40 while in WAIT with response due next cycle → that response is discarded, IF/ID=NOP with validF=0, next request addr=0x40.
- PCSrcD=1 together with hazardDetected=1 → no redirect, PC unchanged, IF/ID holds.
- imem_ready withheld for 4 cycles → imem_req stays 1 with a stable addr, and IF/ID shows NOP bubbles (validF=0) each cycle.
- pc=0xFFFF_FFFC fetch completes → PCReg=0x0, next addr=0x0; assert reset during WAIT → outputs return to their reset values immediately and the late imem_valid is ignored.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared fetch-stage types and constants for the MIPS pipeline.
package pipeline_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
    localparam word_t NOP_INSTR = 32'h0000_0000;
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t REQ  = 2'd0;
    localparam fetch_state_t WAIT = 2'd1;
    localparam fetch_state_t HOLD = 2'd2;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: decode control, instruction-memory bus and IF/ID outputs of the fetch stage.
interface instruction_fetch_if;
    import pipeline_pkg::*;
    logic  hazardDetected;
    logic  PCSrcD;
    word_t PCbranchD;
    logic  imem_req;
    word_t imem_addr;
    logic  imem_ready;
    logic  imem_valid;
    word_t imem_rdata;
    word_t instructionReg;
    word_t PCReg;
    logic  validF;
    modport master(
        input  hazardDetected, PCSrcD, PCbranchD, imem_ready, imem_valid, imem_rdata,
        output imem_req, imem_addr, instructionReg, PCReg, validF
    );
    modport slave(
        output hazardDetected, PCSrcD, PCbranchD, imem_ready, imem_valid, imem_rdata,
        input  imem_req, imem_addr, instructionReg, PCReg, validF
    );
endinterface

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry holding register for a response that arrives while decode stalls.
module fetch_skid_buffer
    import pipeline_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load_i,
    input  logic  clear_i,
    input  word_t instr_i,
    input  word_t pc_i,
    output word_t instr_o,
    output word_t pc_o,
    output logic  full_o
);
    word_t instr_q, pc_q;
    logic  full_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            full_q  <= 1'b0;
        end else begin
            full_q <= clear_i ? 1'b0 : (load_i | full_q);
            if (load_i) begin
                instr_q <= instr_i;
                pc_q    <= pc_i;
            end
        end
    end
    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign full_o  = full_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner and single-outstanding instruction-memory requester feeding IF/ID,
// with decode stall, branch redirect and wrong-path response discard.
module instruction_fetch
    import pipeline_pkg::*;
#(
    parameter word_t RESET_PC  = 32'h0000_0000,
    parameter word_t NOP_INSTR = 32'h0000_0000
) (
    input logic clk,
    input logic reset,
    instruction_fetch_if.master f
);
    fetch_state_t state_q, state_d;
    word_t pc_q, pc_d, instr_q, instr_d, pcreg_q, pcreg_d;
    logic  discard_q, discard_d, valid_q, valid_d;
    logic  redirect, resp_take, skid_out, skid_load, skid_full, deliver;
    word_t pc_plus4, skid_instr, skid_pc;
    assign pc_plus4  = pc_q + 32'd4;
    assign redirect  = f.PCSrcD & ~f.hazardDetected;
    assign resp_take = (state_q == WAIT) & f.imem_valid & ~discard_q & ~redirect;
    assign skid_load = resp_take & f.hazardDetected;
    assign skid_out  = (state_q == HOLD) & skid_full & ~f.hazardDetected & ~redirect;
    assign deliver   = (resp_take & ~f.hazardDetected) | skid_out;
    fetch_skid_buffer u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (redirect | skid_out),
        .instr_i (f.imem_rdata),
        .pc_i    (pc_plus4),
        .instr_o (skid_instr),
        .pc_o    (skid_pc),
        .full_o  (skid_full)
    );
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        pc_d      = resp_take ? pc_plus4 : pc_q;
        case (state_q)
            // acceptance during a redirect fetches the stale address, so its response must be dropped
            REQ:  if (f.imem_ready) begin
                      state_d   = WAIT;
                      discard_d = redirect;
                  end
            WAIT: if (f.imem_valid) begin
                      state_d   = skid_load ? HOLD : REQ;
                      discard_d = 1'b0;
                  end else if (redirect) begin
                      discard_d = 1'b1;
                  end
            HOLD: if (!f.hazardDetected) state_d = REQ;
            default: state_d = REQ;
        endcase
        if (redirect) pc_d = f.PCbranchD;
    end
    assign instr_d = f.hazardDetected ? instr_q : deliver ? (skid_out ? skid_instr : f.imem_rdata) : NOP_INSTR;
    assign pcreg_d = f.hazardDetected ? pcreg_q : deliver ? (skid_out ? skid_pc : pc_plus4) : '0;
    assign valid_d = f.hazardDetected ? valid_q : deliver;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= REQ;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            instr_q   <= NOP_INSTR;
            pcreg_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            instr_q   <= instr_d;
            pcreg_q   <= pcreg_d;
            valid_q   <= valid_d;
        end
    end
    assign f.imem_req       = (state_q == REQ) & ~reset;
    assign f.imem_addr      = pc_q;
    assign f.instructionReg = instr_q;
    assign f.PCReg          = pcreg_q;
    assign f.validF         = valid_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed stimulus against a transaction-level fetch model plus pinned literals.
module tb_instruction_fetch;
    import pipeline_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    instruction_fetch_if bus();
    instruction_fetch dut (.clk(clk), .reset(reset), .f(bus));
    int n_tests = 0;
    int n_fail = 0;
    int lat = 1;
    logic mem_pend = 1'b0;
    int mem_cnt = 0;
    word_t mem_addr = '0;
    word_t m_pc, m_ii, m_ip;
    logic m_v, m_busy, m_disc;
    word_t sk_i[$];
    word_t sk_p[$];
    function automatic word_t memf(input word_t a);
        return (a == 32'h0) ? 32'h2001_0005 : (a == 32'h4) ? 32'h8C22_0000 : (a ^ 32'hDEAD_0000);
    endfunction
    task automatic chk(input string nm, input word_t act, input word_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask
    task automatic model_reset();
        m_pc = 32'h0; m_ii = 32'h0; m_ip = 32'h0; m_v = 1'b0; m_busy = 1'b0; m_disc = 1'b0;
        sk_i.delete(); sk_p.delete();
    endtask
    task automatic model_step(input logic h, input logic ps, input word_t tgt, input logic rdy,
                              input logic vld, input word_t rd);
        logic redir, got;
        word_t gi, gp;
        redir = ps & !h; got = 1'b0; gi = 32'h0; gp = 32'h0;
        if (sk_i.size() != 0) begin
            if (!h) begin
                if (!redir) begin got = 1'b1; gi = sk_i[0]; gp = sk_p[0]; end
                sk_i.delete(); sk_p.delete();
            end
        end else if (m_busy) begin
            if (vld) begin
                m_busy = 1'b0;
                if (!m_disc && !redir) begin
                    m_pc = m_pc + 32'd4;
                    if (h) begin sk_i.push_back(rd); sk_p.push_back(m_pc); end
                    else begin got = 1'b1; gi = rd; gp = m_pc; end
                end
                m_disc = 1'b0;
            end else if (redir) m_disc = 1'b1;
        end else if (rdy) begin
            m_busy = 1'b1; m_disc = redir;
        end
        if (redir) begin m_pc = tgt; sk_i.delete(); sk_p.delete(); end
        if (!h) begin m_ii = got ? gi : NOP_INSTR; m_ip = gp; m_v = got; end
    endtask
    task automatic compare();
        logic er;
        er = !reset && !m_busy && sk_i.size() == 0;
        chk("imem_req", {31'b0, bus.imem_req}, {31'b0, er});
        if (er) chk("imem_addr", bus.imem_addr, m_pc);
        chk("instructionReg", bus.instructionReg, m_ii);
        chk("validF", {31'b0, bus.validF}, {31'b0, m_v});
        if (m_v) chk("PCReg", bus.PCReg, m_ip);
    endtask
    task automatic cyc(input logic h, input logic ps, input word_t tgt, input logic rdy);
        logic vld;
        @(negedge clk);
        vld = mem_pend && mem_cnt == 0;
        bus.hazardDetected = h; bus.PCSrcD = ps; bus.PCbranchD = tgt; bus.imem_ready = rdy;
        bus.imem_valid = vld; bus.imem_rdata = vld ? memf(mem_addr) : 32'h0;
        #1 compare();
        if (reset) model_reset();
        else model_step(h, ps, tgt, rdy, vld, bus.imem_rdata);
        if (vld) mem_pend = 1'b0;
        else if (mem_pend) mem_cnt--;
        if (bus.imem_req && rdy) begin mem_pend = 1'b1; mem_addr = bus.imem_addr; mem_cnt = lat - 1; end
    endtask
    initial begin
        bus.hazardDetected = 1'b0; bus.PCSrcD = 1'b0; bus.PCbranchD = '0;
        bus.imem_ready = 1'b0; bus.imem_valid = 1'b0; bus.imem_rdata = '0;
        model_reset();
        #2;
        chk("rst_instr", bus.instructionReg, 32'h0);
        chk("rst_pcreg", bus.PCReg, 32'h0);
        chk("rst_valid", {31'b0, bus.validF}, 32'h0);
        chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
        cyc(0, 0, 0, 0);
        reset = 1'b0;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 1);
        chk("first_instr", bus.instructionReg, 32'h2001_0005);
        chk("first_pcreg", bus.PCReg, 32'h4);
        chk("first_valid", {31'b0, bus.validF}, 32'h1);
        chk("first_next_addr", bus.imem_addr, 32'h4);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("stall_hold_instr", bus.instructionReg, 32'h2001_0005);
        chk("stall_no_req", {31'b0, bus.imem_req}, 32'h0);
        cyc(0, 0, 0, 0);
        lat = 2;
        cyc(0, 0, 0, 1);
        chk("skid_instr", bus.instructionReg, 32'h8C22_0000);
        chk("skid_pcreg", bus.PCReg, 32'h8);
        chk("skid_addr", bus.imem_addr, 32'h8);
        cyc(0, 1, 32'h40, 0);
        cyc(0, 0, 0, 0);
        chk("redirect_bubble", {31'b0, bus.validF}, 32'h0);
        chk("redirect_nop", bus.instructionReg, 32'h0);
        cyc(1, 1, 32'h80, 0);
        chk("redirect_addr", bus.imem_addr, 32'h40);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0);
            chk("stalled_mem_req", {31'b0, bus.imem_req}, 32'h1);
            chk("stalled_mem_addr", bus.imem_addr, 32'h40);
            chk("stalled_mem_bubble", {31'b0, bus.validF}, 32'h0);
        end
        lat = 1;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 32'hFFFF_FFFC, 0);
        chk("target_instr", bus.instructionReg, 32'hDEAD_0040);
        chk("target_pcreg", bus.PCReg, 32'h44);
        cyc(0, 0, 0, 1);
        chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 32'h100, 1);
        chk("wrap_instr", bus.instructionReg, 32'h2152_FFFC);
        chk("wrap_pcreg", bus.PCReg, 32'h0);
        chk("wrap_next_addr", bus.imem_addr, 32'h0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("accept_redirect_addr", bus.imem_addr, 32'h100);
        cyc(0, 0, 0, 0);
        lat = 3;
        cyc(1, 0, 0, 1);
        chk("pre_reset_instr", bus.instructionReg, 32'hDEAD_0100);
        cyc(1, 0, 0, 0);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_instr", bus.instructionReg, 32'h0);
        chk("async_rst_pcreg", bus.PCReg, 32'h0);
        chk("async_rst_valid", {31'b0, bus.validF}, 32'h0);
        chk("async_rst_req", {31'b0, bus.imem_req}, 32'h0);
        model_reset();
        cyc(0, 0, 0, 0);
        reset = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("late_valid_ignored", {31'b0, bus.validF}, 32'h0);
        chk("late_valid_addr", bus.imem_addr, 32'h0);
        lat = 1;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("refetch_instr", bus.instructionReg, 32'h2001_0005);
        chk("refetch_pcreg", bus.PCReg, 32'h4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
